// File: rtl/fetch_bundle_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_bundle_queue_pkg
// Shared fetch configuration for the fetch bundle queue: PC width, fetch
// width, instruction bundle width and the layout of one queued entry.
// Ports: none (package).
// ---------------------------------------------------------------------------
package fetch_bundle_queue_pkg;

  localparam int SIZE_PC            = 32;
  localparam int FETCH_WIDTH        = 4;
  localparam int INSN_BYTES         = 8;
  localparam int INSTRUCTION_BUNDLE = FETCH_WIDTH * INSN_BYTES * 8;
  localparam int TARGETS_W          = FETCH_WIDTH * SIZE_PC;

  // One fetch bundle with its per-slot branch prediction state.
  typedef struct packed {
    logic [TARGETS_W-1:0]          targetAddr;
    logic [FETCH_WIDTH-1:0]        prediction;
    logic [FETCH_WIDTH-1:0]        btbHit;
    logic [INSTRUCTION_BUNDLE-1:0] bundle;
    logic [SIZE_PC-1:0]            pc;
  } fbq_entry_t;

  // Extract the predicted target of slot k (slot 0 sits in the low bits).
  function automatic logic [SIZE_PC-1:0] slot_target(input logic [TARGETS_W-1:0] t,
                                                     input int k);
    return t[k*SIZE_PC +: SIZE_PC];
  endfunction

endpackage

// File: rtl/fetch_bundle_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_bundle_queue_if
// Handshake and payload bundle between Fetch stage 1 (enqueue side),
// the fetch bundle queue and Fetch stage 2 (dequeue side).
//   slave  : the queue itself
//   master : the surrounding fetch logic (drives enqueue, flush, deqReady)
// Signals: flush_i, enqValid_i/enqReady_o, pc_i, instructionBundle_i,
//          btbHit_i, prediction_i, targetAddr_i, deqValid_o/deqReady_i,
//          pc_o, instructionBundle_o, btbHit_o, prediction_o,
//          targetAddr_o, count_o, stall_o.
// ---------------------------------------------------------------------------
interface fetch_bundle_queue_if
  import fetch_bundle_queue_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                          flush_i;
  logic                          enqValid_i;
  logic                          enqReady_o;
  logic [SIZE_PC-1:0]            pc_i;
  logic [INSTRUCTION_BUNDLE-1:0] instructionBundle_i;
  logic [FETCH_WIDTH-1:0]        btbHit_i;
  logic [FETCH_WIDTH-1:0]        prediction_i;
  logic [TARGETS_W-1:0]          targetAddr_i;

  logic                          deqValid_o;
  logic                          deqReady_i;
  logic [SIZE_PC-1:0]            pc_o;
  logic [INSTRUCTION_BUNDLE-1:0] instructionBundle_o;
  logic [FETCH_WIDTH-1:0]        btbHit_o;
  logic [FETCH_WIDTH-1:0]        prediction_o;
  logic [TARGETS_W-1:0]          targetAddr_o;
  logic [CNT_W-1:0]              count_o;
  logic                          stall_o;

  modport slave (
    input  flush_i, enqValid_i, pc_i, instructionBundle_i, btbHit_i,
           prediction_i, targetAddr_i, deqReady_i,
    output enqReady_o, deqValid_o, pc_o, instructionBundle_o, btbHit_o,
           prediction_o, targetAddr_o, count_o, stall_o
  );

  modport master (
    output flush_i, enqValid_i, pc_i, instructionBundle_i, btbHit_i,
           prediction_i, targetAddr_i, deqReady_i,
    input  enqReady_o, deqValid_o, pc_o, instructionBundle_o, btbHit_o,
           prediction_o, targetAddr_o, count_o, stall_o
  );

endinterface

// File: rtl/fbq_ctrl.sv
// ---------------------------------------------------------------------------
// fbq_ctrl
// Head/tail pointers and occupancy counter of the fetch bundle queue.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_flush             drop every queued bundle on the next edge
//   i_enq_valid         producer offers a bundle
//   i_deq_ready         consumer takes the head bundle
//   o_head, o_tail      storage indices of the oldest entry / next free slot
//   o_count             occupancy, 0..DEPTH
//   o_wr_en             write the offered bundle at o_tail this cycle
//   o_enq_ready         queue not full
//   o_deq_valid         queue not empty
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module fbq_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_flush,
  input  logic                       i_enq_valid,
  input  logic                       i_deq_ready,
  output logic [$clog2(DEPTH)-1:0]   o_head,
  output logic [$clog2(DEPTH)-1:0]   o_tail,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_wr_en,
  output logic                       o_enq_ready,
  output logic                       o_deq_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_enq_ready;
  logic w_deq_valid;
  logic w_enq;
  logic w_deq;

  // Readiness looks only at the current count, so a full queue refuses a
  // bundle even if the head leaves in the same cycle.
  assign w_enq_ready = (r_count != CNT_W'(DEPTH));
  assign w_deq_valid = (r_count != '0);
  assign w_enq       = i_enq_valid & w_enq_ready & ~i_flush;
  assign w_deq       = w_deq_valid & i_deq_ready & ~i_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_deq) r_head <= r_head + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head      = r_head;
  assign o_tail      = r_tail;
  assign o_count     = r_count;
  assign o_wr_en     = w_enq;
  assign o_enq_ready = w_enq_ready;
  assign o_deq_valid = w_deq_valid;

endmodule

// File: rtl/fetch_bundle_queue.sv
// ---------------------------------------------------------------------------
// fetch_bundle_queue
// Circular FIFO of fetch bundles between Fetch stage 1 and Fetch stage 2.
// No bypass: a bundle accepted in cycle N is first visible at the output in
// cycle N+1. The head payload is read combinationally from storage.
// Ports:
//   clk    clock (rising edge)
//   reset  synchronous active-high reset
//   bus    fetch_bundle_queue_if.slave: enqueue/dequeue handshake, payload,
//          flush, occupancy and stall back-pressure
// ---------------------------------------------------------------------------
module fetch_bundle_queue
  import fetch_bundle_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_bundle_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] w_head;
  logic [PTR_W-1:0] w_tail;
  logic [PTR_W:0]   w_count;
  logic             w_wr_en;
  logic             w_enq_ready;
  logic             w_deq_valid;
  fbq_entry_t       w_wr_entry;
  fbq_entry_t       w_head_entry;

  // Payload storage: written only on an accepted enqueue, never reset.
  fbq_entry_t r_mem [DEPTH];

  fbq_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (bus.flush_i),
    .i_enq_valid (bus.enqValid_i),
    .i_deq_ready (bus.deqReady_i),
    .o_head      (w_head),
    .o_tail      (w_tail),
    .o_count     (w_count),
    .o_wr_en     (w_wr_en),
    .o_enq_ready (w_enq_ready),
    .o_deq_valid (w_deq_valid)
  );

  assign w_wr_entry.pc         = bus.pc_i;
  assign w_wr_entry.bundle     = bus.instructionBundle_i;
  assign w_wr_entry.btbHit     = bus.btbHit_i;
  assign w_wr_entry.prediction = bus.prediction_i;
  assign w_wr_entry.targetAddr = bus.targetAddr_i;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_tail] <= w_wr_entry;
  end

  assign w_head_entry = r_mem[w_head];

  assign bus.pc_o                = w_head_entry.pc;
  assign bus.instructionBundle_o = w_head_entry.bundle;
  assign bus.btbHit_o            = w_head_entry.btbHit;
  assign bus.prediction_o        = w_head_entry.prediction;
  assign bus.targetAddr_o        = w_head_entry.targetAddr;

  assign bus.deqValid_o = w_deq_valid;
  assign bus.enqReady_o = w_enq_ready;
  assign bus.stall_o    = ~w_enq_ready;
  assign bus.count_o    = w_count;

endmodule

// File: doc/fetch_bundle_queue.md
FETCH_BUNDLE_QUEUE -- requirements
Module: fetch_bundle_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of bundle entries; power of two, minimum 2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush_i  input  1  discard all queued bundles (fetch redirect or exception).
REQ-005 enqValid_i  input  1  Fetch stage 1 presents a bundle (fs1Ready_o & ~stall).
REQ-006 enqReady_o  output  1  queue can accept a bundle this cycle.
REQ-007 pc_i  input  SIZE_PC  PC of the first instruction in the bundle.
REQ-008 instructionBundle_i  input  INSTRUCTION_BUNDLE  four instructions, 8 bytes each.
REQ-009 btbHit_i, prediction_i  input  4 each  per-slot BTB hit and direction prediction, bit k = slot k.
REQ-010 targetAddr_i  input  4 x SIZE_PC  per-slot predicted targets, slot 0 in the low bits.
REQ-011 deqValid_o  output  1  the head entry is valid.
REQ-012 deqReady_i  input  1  Fetch stage 2 consumes the head this cycle.
REQ-013 pc_o, instructionBundle_o, btbHit_o, prediction_o, targetAddr_o  output  same widths as the inputs  head entry payload.
REQ-014 count_o  output  log2(DEPTH)+1  current occupancy.
REQ-015 stall_o  output  1  equals ~enqReady_o; used as stall_i back-pressure to Fetch stage 1.

Function
REQ-016 The queue SHALL be a circular FIFO with head pointer, tail pointer and an occupancy counter; pointers wrap modulo DEPTH.
- REQ-017 Enqueue occurs when enqValid_i & enqReady_o & ~flush_i.
  - The payload is written at the tail.
  - The tail advances by 1.
- REQ-018 Dequeue occurs when deqValid_o & deqReady_i & ~flush_i.
  - The head advances by 1.
- REQ-019 enqReady_o = (count_o != DEPTH).
  - A full queue SHALL NOT accept an enqueue, even when a dequeue occurs in the same cycle.
- REQ-020 deqValid_o = (count_o != 0); there is no bypass, so a bundle enqueued in cycle N is first visible at the output in cycle N+1.
- REQ-021 Simultaneous enqueue and dequeue SHALL leave count_o unchanged; enqueue only increments it, dequeue only decrements it.
- REQ-022 Output payload SHALL be driven combinationally from the head entry storage.
  - Payload outputs are don't-care while deqValid_o=0.
- REQ-023 flush_i SHALL set head, tail and count to 0 on the next edge.
  - flush_i has priority over any simultaneous enqueue or dequeue; both are dropped.
- REQ-024 Ordering SHALL be strict FIFO; entries are never reordered or duplicated.
- REQ-025 Payload storage SHALL be written only on enqueue; it has no reset and need not be cleared on flush.

Reset
REQ-026 On reset, head=0, tail=0, count_o=0, deqValid_o=0, enqReady_o=1 and stall_o=0.
REQ-027 Reset SHALL take priority over flush_i, enqueue and dequeue.
REQ-028 Reset asserted mid-operation SHALL discard all entries by the next edge.

Structure
REQ-029 SIZE_PC, INSTRUCTION_BUNDLE and the fetch width (4) SHALL come from the shared FabScalar configuration/define package; the entry field layout belongs there too.
REQ-030 The pointer/counter control SHALL live in one sub-module, fbq_ctrl.
  - fbq_ctrl outputs: head, tail, count, the write enable and the two ready/valid flags.
  - The top level holds the storage arrays and the output muxing.

Verification
REQ-031 Reset then idle:
- 5 cycles with no stimulus -> count_o=0, deqValid_o=0, enqReady_o=1 throughout.
REQ-032 Fill/drain:
- Enqueue 4 bundles with pc_i=0x100,0x120,0x140,0x160 while deqReady_i=0 -> count_o reaches 4 and enqReady_o=0.
- A 5th enqValid_i is ignored.
- Then hold deqReady_i=1 -> pc_o sequence is 0x100,0x120,0x140,0x160, after which deqValid_o=0.
REQ-033 Wrap-around:
- Continuous enqueue and dequeue for 10 cycles at count 2, PCs incrementing by 0x20 -> count_o stays 2.
- Output PCs are in order with no gaps across the pointer wrap.
REQ-034 Full with simultaneous dequeue:
- count=4, enqValid_i=1, deqReady_i=1 -> the dequeue occurs, the enqueue is rejected, and count_o=3.
REQ-035 Flush:
- count=3, flush_i=1 with enqValid_i=1 and deqReady_i=1 -> next cycle count_o=0 and deqValid_o=0.
- The next enqueue with pc_i=0x400 appears at pc_o one cycle later.
REQ-036 Payload integrity:
- Enqueue btbHit_i=4'b0100, prediction_i=4'b0100, slot-2 target 0x2000 -> the dequeued entry shows identical fields.
